// File: rtl/vga_plot_arbiter.sv
// Framebuffer write-port sequencer: full-screen clear from the background RAM,
// then round-robin sharing of the plot port between two drawing clients.
module vga_plot_arbiter #(
  parameter int XMAX = 159,
  parameter int YMAX = 119,
  parameter int CW   = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic [14:0]   bg_address,
  input  logic          bg_q,
  input  logic          a_req,
  input  logic [7:0]    a_x,
  input  logic [7:0]    a_y,
  input  logic [CW-1:0] a_color,
  input  logic          b_req,
  input  logic [7:0]    b_x,
  input  logic [7:0]    b_y,
  input  logic [CW-1:0] b_color,
  output logic          a_ack,
  output logic          b_ack,
  output logic [7:0]    vga_x,
  output logic [7:0]    vga_y,
  output logic [CW-1:0] vga_color,
  output logic          vga_plot
);

  localparam int          NPIX   = (XMAX + 1) * (YMAX + 1);
  localparam logic [14:0] LAST_N = 15'(NPIX - 1);
  localparam logic [7:0]  XLAST  = 8'(XMAX);
  localparam logic [7:0]  YLAST  = 8'(YMAX);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_DRAIN,
    S_SERVE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [14:0]   r_n;
  logic [7:0]    r_col;
  logic [7:0]    r_row;
  logic          r_ptr;       // 0 = client A preferred, 1 = client B preferred

  logic          r_plot;
  logic          r_clr_out;   // current vga_* beat belongs to the clear stream
  logic [7:0]    r_x;
  logic [7:0]    r_y;
  logic [CW-1:0] r_color;

  logic          w_grant_a;
  logic          w_grant_b;
  logic          w_grant;
  logic [7:0]    w_sel_x;
  logic [7:0]    w_sel_y;
  logic [CW-1:0] w_sel_color;
  logic          w_in_range;
  logic          w_last_n;

  assign w_last_n = (r_n == LAST_N);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        if (w_last_n) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_state_nxt = S_SERVE;
      end
      S_SERVE: begin
        // A clear request takes the port before any client this cycle
        if (clear_start) begin
          w_state_nxt = S_CLEAR;
        end else if (a_req && (!b_req || !r_ptr)) begin
          w_grant_a = 1'b1;
        end else if (b_req) begin
          w_grant_b = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  assign w_grant     = w_grant_a | w_grant_b;
  assign w_sel_x     = w_grant_b ? b_x     : a_x;
  assign w_sel_y     = w_grant_b ? b_y     : a_y;
  assign w_sel_color = w_grant_b ? b_color : a_color;
  assign w_in_range  = (w_sel_x <= XLAST) && (w_sel_y <= YLAST);

  // Stage boundary: address/grant cycle -> registered write-port cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_CLEAR;
      r_n       <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_ptr     <= 1'b0;
      r_plot    <= 1'b0;
      r_clr_out <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_color   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_plot    <= 1'b0;
      r_clr_out <= 1'b0;
      unique case (r_state)
        S_CLEAR: begin
          // Column/row of address n land on vga_* together with bg_q for n
          r_x       <= r_col;
          r_y       <= r_row;
          r_plot    <= 1'b1;
          r_clr_out <= 1'b1;
          if (w_last_n) begin
            r_n   <= '0;
            r_col <= '0;
            r_row <= '0;
          end else begin
            r_n <= r_n + 15'd1;
            if (r_col == XLAST) begin
              r_col <= '0;
              r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
          end
        end
        S_SERVE: begin
          if (w_grant) begin
            r_x     <= w_sel_x;
            r_y     <= w_sel_y;
            r_color <= w_sel_color;
            r_plot  <= w_in_range;
            r_ptr   <= w_grant_a;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign clear_busy = (r_state != S_SERVE);
  assign bg_address = r_n;
  assign a_ack      = w_grant_a;
  assign b_ack      = w_grant_b;
  assign vga_x      = r_x;
  assign vga_y      = r_y;
  // bg_q is already one cycle behind its address, so it is used as-is
  assign vga_color  = r_clr_out ? {CW{bg_q}} : r_color;
  assign vga_plot   = r_plot;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: clear streams, client handshakes and round-robin
// order checked against a rule-level reference model.
module tb_vga_plot_arbiter;

  localparam int CW   = 12;
  localparam int XMAX = 159;
  localparam int YMAX = 119;
  localparam int NPIX = (XMAX + 1) * (YMAX + 1);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic [14:0]   bg_address;
  logic          bg_q = 1'b0;
  logic          a_req = 1'b0, b_req = 1'b0;
  logic [7:0]    a_x = '0, a_y = '0, b_x = '0, b_y = '0;
  logic [CW-1:0] a_color = '0, b_color = '0;
  logic          a_ack, b_ack;
  logic [7:0]    vga_x, vga_y;
  logic [CW-1:0] vga_color;
  logic          vga_plot;

  bit bg_mem [NPIX];
  int n_cmp = 0;
  int n_err = 0;
  bit model_ptr = 1'b0;

  vga_plot_arbiter #(.XMAX(XMAX), .YMAX(YMAX), .CW(CW)) dut (
    .clk(clk), .resetn(resetn), .clear_start(clear_start), .clear_busy(clear_busy),
    .bg_address(bg_address), .bg_q(bg_q),
    .a_req(a_req), .a_x(a_x), .a_y(a_y), .a_color(a_color),
    .b_req(b_req), .b_x(b_x), .b_y(b_y), .b_color(b_color),
    .a_ack(a_ack), .b_ack(b_ack),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  // Background RAM with one-cycle registered read
  always @(posedge clk)
    bg_q <= (int'(bg_address) < NPIX) ? bg_mem[int'(bg_address)] : 1'b0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_coord(input int last);
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(last + 1, 255));
    return 8'($urandom_range(0, last));
  endfunction

  // Entered at the negedge of the first CLEAR cycle (n = 0); leaves at the first SERVE cycle.
  task automatic check_clear(input string name, input bit poke_clear);
    int    bad = 0;
    string first = "";
    int    k;
    logic [27:0] exp_pix;
    for (int c = 0; c <= NPIX; c++) begin
      if (poke_clear) clear_start = (c == 100 || c == NPIX);
      #1;
      k = c - 1;
      exp_pix = (c == 0) ? 28'd0 : {8'(k % (XMAX + 1)), 8'(k / (XMAX + 1)), {CW{bg_mem[(c == 0) ? 0 : k]}}};
      if ((c < NPIX && bg_address !== 15'(c)) || clear_busy !== 1'b1 ||
          a_ack !== 1'b0 || b_ack !== 1'b0 ||
          (c == 0 && vga_plot !== 1'b0) ||
          (c > 0 && {vga_plot, vga_x, vga_y, vga_color} !== {1'b1, exp_pix})) begin
        if (bad == 0)
          first = $sformatf("cycle %0d: addr=%0d busy=%b ack=%b%b plot=%b xy=(%0d,%0d) col=%h, required addr=%0d busy=1 ack=00 plot=%b xy=(%0d,%0d) col=%h",
                            c, bg_address, clear_busy, a_ack, b_ack, vga_plot, vga_x, vga_y, vga_color,
                            c, (c > 0), exp_pix[27:20], exp_pix[19:12], exp_pix[11:0]);
        bad++;
      end
      tick();
    end
    clear_start = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s: %0d bad cycles, first at %s", name, bad, first);
    end
    #1;
    n_cmp++;
    if ({clear_busy, vga_plot} !== 2'b00) begin
      n_err++;
      $display("FAIL %s_end: busy=%b plot=%b, required busy=0 plot=0", name, clear_busy, vga_plot);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    a_x = 8'd1; a_y = 8'd2; b_x = 8'd3; b_y = 8'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_cmp++;
      if ({vga_plot, vga_x, vga_y, vga_color} !== 29'd0) begin
        n_err++;
        $display("FAIL reset_vga: plot=%b x=%0d y=%0d col=%h, required all 0", vga_plot, vga_x, vga_y, vga_color);
      end
      n_cmp++;
      if (bg_address !== 15'd0 || a_ack !== 1'b0 || b_ack !== 1'b0 || clear_busy !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ctrl: addr=%0d ack=%b%b busy=%b, required addr=0 ack=00 busy=1",
                 bg_address, a_ack, b_ack, clear_busy);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    resetn = 1'b1;
    check_clear("boot_clear", 1'b0);
    model_ptr = 1'b0;
  endtask

  task automatic test_single;
    a_req = 1'b1; a_x = 8'd10; a_y = 8'd20; a_color = 12'hF00;
    #1;
    n_cmp++;
    if ({a_ack, b_ack} !== 2'b10) begin
      n_err++;
      $display("FAIL single_ack: ack=%b%b, required 10", a_ack, b_ack);
    end
    tick();
    a_req = 1'b0;
    #1;
    n_cmp++;
    if ({vga_plot, vga_x, vga_y, vga_color} !== {1'b1, 8'd10, 8'd20, 12'hF00}) begin
      n_err++;
      $display("FAIL single_pixel: plot=%b (%0d,%0d) %h, required 1 (10,20) f00", vga_plot, vga_x, vga_y, vga_color);
    end
    tick();
    #1;
    n_cmp++;
    if (vga_plot !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: plot=%b, required 0", vga_plot);
    end
    model_ptr = 1'b1;
  endtask

  // Corner (159,119) is drawn; y = 120 and x = 160 are consumed without a plot.
  task automatic test_range;
    logic [7:0] xs [3];
    logic [7:0] ys [3];
    bit         use_b [3];
    bit         plot_ok [3];
    xs = '{8'd159, 8'd3, 8'd160};
    ys = '{8'd119, 8'd120, 8'd5};
    use_b = '{1'b0, 1'b0, 1'b1};
    plot_ok = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      if (use_b[i]) begin b_req = 1'b1; b_x = xs[i]; b_y = ys[i]; b_color = 12'($urandom); end
      else          begin a_req = 1'b1; a_x = xs[i]; a_y = ys[i]; a_color = 12'($urandom); end
      #1;
      n_cmp++;
      if ({a_ack, b_ack} !== {!use_b[i], use_b[i]}) begin
        n_err++;
        $display("FAIL range_ack%0d: ack=%b%b, required %b%b", i, a_ack, b_ack, !use_b[i], use_b[i]);
      end
      tick();
      a_req = 1'b0; b_req = 1'b0;
      #1;
      n_cmp++;
      if (vga_plot !== plot_ok[i] || (plot_ok[i] && {vga_x, vga_y} !== {xs[i], ys[i]})) begin
        n_err++;
        $display("FAIL range_plot%0d: plot=%b (%0d,%0d), required plot=%b (%0d,%0d)",
                 i, vga_plot, vga_x, vga_y, plot_ok[i], xs[i], ys[i]);
      end
      model_ptr = !use_b[i];
    end
  endtask

  task automatic test_back_to_back;
    logic [27:0] ep;
    bit          exp_a;
    a_req = 1'b1; b_req = 1'b1;
    a_x = rand_coord(XMAX); a_y = 8'($urandom_range(0, YMAX)); a_color = 12'($urandom);
    b_x = 8'($urandom_range(0, XMAX)); b_y = 8'($urandom_range(0, YMAX)); b_color = 12'($urandom);
    a_x = 8'($urandom_range(0, XMAX));
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_a = (i % 2 == 0);
      n_cmp++;
      if ({a_ack, b_ack} !== {exp_a, !exp_a}) begin
        n_err++;
        $display("FAIL b2b_ack%0d: ack=%b%b, required %b%b", i, a_ack, b_ack, exp_a, !exp_a);
      end
      ep = exp_a ? {a_x, a_y, a_color} : {b_x, b_y, b_color};
      tick();
      if (i == 5) begin
        a_req = 1'b0; b_req = 1'b0;
      end else if (exp_a) begin
        a_x = 8'($urandom_range(0, XMAX)); a_y = 8'($urandom_range(0, YMAX)); a_color = 12'($urandom);
      end else begin
        b_x = 8'($urandom_range(0, XMAX)); b_y = 8'($urandom_range(0, YMAX)); b_color = 12'($urandom);
      end
      #1;
      n_cmp++;
      if ({vga_plot, vga_x, vga_y, vga_color} !== {1'b1, ep}) begin
        n_err++;
        $display("FAIL b2b_pixel%0d: plot=%b (%0d,%0d) %h, required 1 (%0d,%0d) %h",
                 i, vga_plot, vga_x, vga_y, vga_color, ep[27:20], ep[19:12], ep[11:0]);
      end
    end
    tick();
    model_ptr = 1'b0;
  endtask

  // Randomised clients that hold req/data until acked, scored against the arbitration rules.
  task automatic test_random;
    bit          ah = 1'b0, bh = 1'b0, ga, gb, exp_plot = 1'b0;
    logic [27:0] ep = '0;
    for (int i = 0; i <= 400; i++) begin
      if (i < 400) begin
        if (!ah && $urandom_range(0, 9) < 6) begin
          ah = 1'b1; a_x = rand_coord(XMAX); a_y = rand_coord(YMAX); a_color = 12'($urandom);
        end
        if (!bh && $urandom_range(0, 9) < 6) begin
          bh = 1'b1; b_x = rand_coord(XMAX); b_y = rand_coord(YMAX); b_color = 12'($urandom);
        end
      end else begin
        ah = 1'b0; bh = 1'b0;
      end
      a_req = ah; b_req = bh;
      #1;
      n_cmp++;
      if (vga_plot !== exp_plot || (exp_plot && {vga_x, vga_y, vga_color} !== ep)) begin
        n_err++;
        $display("FAIL rand_pixel@%0d: plot=%b (%0d,%0d) %h, required plot=%b (%0d,%0d) %h",
                 i, vga_plot, vga_x, vga_y, vga_color, exp_plot, ep[27:20], ep[19:12], ep[11:0]);
      end
      ga = ah && (!bh || model_ptr == 1'b0);
      gb = bh && !ga;
      n_cmp++;
      if ({a_ack, b_ack} !== {ga, gb}) begin
        n_err++;
        $display("FAIL rand_ack@%0d: ack=%b%b, required %b%b", i, a_ack, b_ack, ga, gb);
      end
      if (ga || gb) begin
        ep = ga ? {a_x, a_y, a_color} : {b_x, b_y, b_color};
        exp_plot = (int'(ep[27:20]) <= XMAX) && (int'(ep[19:12]) <= YMAX);
        model_ptr = ga;
        if (ga) ah = 1'b0; else bh = 1'b0;
      end else begin
        exp_plot = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_clear_start;
    a_req = 1'b1; a_x = 8'd7; a_y = 8'd8; a_color = 12'hABC;
    clear_start = 1'b1;
    #1;
    n_cmp++;
    if ({a_ack, b_ack} !== 2'b00) begin
      n_err++;
      $display("FAIL clrstart_ack: ack=%b%b, required 00", a_ack, b_ack);
    end
    tick();
    clear_start = 1'b0;
    check_clear("requested_clear", 1'b1);
    n_cmp++;
    if ({a_ack, b_ack} !== 2'b10) begin
      n_err++;
      $display("FAIL clrstart_post_ack: ack=%b%b, required 10", a_ack, b_ack);
    end
    tick();
    a_req = 1'b0;
    #1;
    n_cmp++;
    if ({vga_plot, vga_x, vga_y, vga_color} !== {1'b1, 8'd7, 8'd8, 12'hABC}) begin
      n_err++;
      $display("FAIL clrstart_pixel: plot=%b (%0d,%0d) %h, required 1 (7,8) abc", vga_plot, vga_x, vga_y, vga_color);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear;
    int waited = 0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    while (bg_address !== 15'd5000 && waited < 6000) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (waited >= 6000) begin
      n_err++;
      $display("FAIL midclr_reach: addr=%0d after %0d cycles, required 5000", bg_address, waited);
    end
    resetn = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (vga_plot !== 1'b0 || bg_address !== 15'd0 || clear_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midclr_reset: plot=%b addr=%0d busy=%b, required 0 0 1", vga_plot, bg_address, clear_busy);
    end
    resetn = 1'b1;
    check_clear("restart_clear", 1'b0);
    a_req = 1'b1; b_req = 1'b1;
    #1;
    n_cmp++;
    if ({a_ack, b_ack} !== 2'b10) begin
      n_err++;
      $display("FAIL midclr_ptr: ack=%b%b, required 10", a_ack, b_ack);
    end
    tick();
    a_req = 1'b0; b_req = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) bg_mem[i] = 1'($urandom_range(0, 1));
    test_reset();
    test_single();
    test_range();
    test_back_to_back();
    test_random();
    test_clear_start();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
